// File: rtl/entity_trigger_scheduler.sv
// Frame-level entity scheduler. On each accepted frame it decides which
// entities are due from their frame dividers. It then triggers them one at a
// time in priority order (index 0 first) and waits for each one's done
// handshake, or for a timeout, before moving on.
module entity_trigger_scheduler #(
    parameter int NUM_ENT = 4,
    parameter int DIV_W   = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     frame_start_i,
    input  logic                     pause_i,
    input  logic [NUM_ENT*DIV_W-1:0] div_cfg_i,
    input  logic [NUM_ENT-1:0]       ent_done_i,
    output logic [NUM_ENT-1:0]       trigger_o,
    output logic                     busy_o,
    output logic [7:0]               frame_count_o,
    output logic                     overrun_o,
    output logic [NUM_ENT-1:0]       timeout_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    localparam logic [DIV_W:0]     DIV_ONE   = (DIV_W+1)'(1);
    localparam logic [NUM_ENT-1:0] ENT_ONE   = NUM_ENT'(1);
    localparam logic [5:0]         TIMER_LIM = 6'(TIMEOUT - 1);

    state_e                     state_q;
    logic [NUM_ENT*DIV_W-1:0]   cnt_q;
    logic [NUM_ENT*DIV_W-1:0]   cnt_d;
    logic [NUM_ENT-1:0]         due_d;
    logic [NUM_ENT-1:0]         mask_q;
    logic [NUM_ENT-1:0]         mask_rem_d;
    logic [NUM_ENT-1:0]         cur_q;
    logic [NUM_ENT-1:0]         trigger_q;
    logic [NUM_ENT-1:0]         timeout_err_q;
    logic [5:0]                 timer_q;
    logic [7:0]                 frame_count_q;
    logic                       overrun_q;
    logic                       accept_d;
    logic                       done_hit_d;
    logic                       timed_out_d;

    // Isolates the lowest set bit, which is the highest-priority pending entity.
    function automatic logic [NUM_ENT-1:0] lowest_bit(input logic [NUM_ENT-1:0] m);
        return m & (~m + ENT_ONE);
    endfunction

    // Per-entity divider: a zero divider behaves like 1 so the entity still runs
    // every frame, and the wider compare keeps cnt+1 from wrapping.
    for (genvar g = 0; g < NUM_ENT; g++) begin : g_div
        logic [DIV_W-1:0] div_w;
        logic [DIV_W-1:0] cnt_w;
        logic [DIV_W:0]   eff_w;
        logic [DIV_W:0]   inc_w;

        assign div_w = div_cfg_i[g*DIV_W +: DIV_W];
        assign cnt_w = cnt_q[g*DIV_W +: DIV_W];
        assign eff_w = (div_w == '0) ? DIV_ONE : {1'b0, div_w};
        assign inc_w = {1'b0, cnt_w} + DIV_ONE;
        assign due_d[g] = (inc_w >= eff_w);
        assign cnt_d[g*DIV_W +: DIV_W] = due_d[g] ? '0 : inc_w[DIV_W-1:0];
    end

    // Frame acceptance and the completion conditions for the entity being served.
    always_comb begin
        accept_d    = frame_start_i && !pause_i && (state_q == ST_IDLE);
        done_hit_d  = |(ent_done_i & cur_q);
        timed_out_d = (timer_q == TIMER_LIM);
        mask_rem_d  = mask_q & ~cur_q;
    end

    // Sequencer: latch the due mask on an accepted frame, then step through it
    // one entity per ISSUE/WAIT pair. Trigger is registered so it is a clean pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mask_q        <= '0;
            cur_q         <= '0;
            trigger_q     <= '0;
            timeout_err_q <= '0;
            timer_q       <= '0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            overrun_q <= frame_start_i && !pause_i && (state_q != ST_IDLE);
            trigger_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_d) begin
                        frame_count_q <= frame_count_q + 8'd1;
                        cnt_q         <= cnt_d;
                        mask_q        <= due_d;
                        if (|due_d) begin
                            cur_q     <= lowest_bit(due_d);
                            trigger_q <= lowest_bit(due_d);
                            state_q   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_hit_d || timed_out_d) begin
                        if (!done_hit_d) begin
                            timeout_err_q <= timeout_err_q | cur_q;
                        end
                        mask_q <= mask_rem_d;
                        if (|mask_rem_d) begin
                            cur_q     <= lowest_bit(mask_rem_d);
                            trigger_q <= lowest_bit(mask_rem_d);
                            state_q   <= ST_ISSUE;
                        end else begin
                            cur_q   <= '0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        timer_q <= timer_q + 6'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign trigger_o     = trigger_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign frame_count_o = frame_count_q;
    assign overrun_o     = overrun_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_entity_trigger_scheduler.sv
// Directed bench for entity_trigger_scheduler: ordered triggering, dividers,
// timeout, overrun, pause, mid-sequence reset and frame counter wrap.
module tb_entity_trigger_scheduler;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        pause;
    logic [15:0] div_cfg;
    logic [3:0]  ent_done;
    logic [3:0]  trigger;
    logic        busy;
    logic [7:0]  frame_count;
    logic        overrun;
    logic [3:0]  timeout_err;

    int checkCount = 0;
    int failCount  = 0;
    int multiHot   = 0;
    int pulseCount = 0;
    int cycIdx     = 0;
    int trigAt [4];
    logic [3:0] seenMask;
    int expFrames  = 0;

    entity_trigger_scheduler #(.NUM_ENT(4), .DIV_W(4), .TIMEOUT(63)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .frame_start_i (frame_start),
        .pause_i       (pause),
        .div_cfg_i     (div_cfg),
        .ent_done_i    (ent_done),
        .trigger_o     (trigger),
        .busy_o        (busy),
        .frame_count_o (frame_count),
        .overrun_o     (overrun),
        .timeout_err_o (timeout_err)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so a stuck design cannot hang the run.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearTrack();
        seenMask   = '0;
        pulseCount = 0;
        cycIdx     = 0;
        for (int i = 0; i < 4; i++) trigAt[i] = -1;
    endtask

    task automatic trackCycle();
        if (trigger != 4'b0000) begin
            seenMask = seenMask | trigger;
            pulseCount++;
            if ((trigger & (trigger - 4'd1)) != 4'b0000) multiHot++;
            for (int i = 0; i < 4; i++) if (trigger[i]) trigAt[i] = cycIdx;
        end
        cycIdx++;
    endtask

    // Drive one cycle of inputs, clock it, and observe just after the edge.
    task automatic applyStimulus(input logic fs, input logic p);
        frame_start = fs;
        pause       = p;
        @(posedge clk);
        #1;
        trackCycle();
    endtask

    task automatic drainFrame(input logic p);
        for (int n = 0; n < 300 && busy; n++) applyStimulus(1'b0, p);
        checkOutput("drainBusy", {31'd0, busy}, 32'd0);
    endtask

    task automatic runFrame();
        clearTrack();
        applyStimulus(1'b1, 1'b0);
        expFrames++;
        drainFrame(1'b0);
    endtask

    logic [3:0] expSeq [8];

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pause       = 1'b0;
        div_cfg     = {4'd1, 4'd1, 4'd1, 4'd1};
        ent_done    = 4'b1111;
        clearTrack();
        #12;
        checkOutput("rstTrigger", {28'd0, trigger}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstFrameCount", {24'd0, frame_count}, 32'd0);
        checkOutput("rstOverrun", {31'd0, overrun}, 32'd0);
        checkOutput("rstTimeoutErr", {28'd0, timeout_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0);

        // Test 1: all dividers 1, done tied high; triggers every other cycle.
        expSeq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        clearTrack();
        applyStimulus(1'b1, 1'b0);
        expFrames++;
        checkOutput("t1Trig0", {28'd0, trigger}, {28'd0, expSeq[0]});
        checkOutput("t1FrameCount", {24'd0, frame_count}, 32'd1);
        checkOutput("t1Busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("t1Trig%0d", i), {28'd0, trigger}, {28'd0, expSeq[i]});
        end
        applyStimulus(1'b0, 1'b0);
        checkOutput("t1BusyLow", {31'd0, busy}, 32'd0);

        // Test 2: entity 1 divides by 3, entity 3 has divider 0 (acts as 1).
        div_cfg = {4'd0, 4'd1, 4'd3, 4'd1};
        for (int f = 1; f <= 6; f++) begin
            runFrame();
            checkOutput($sformatf("t2Frame%0d", f), {28'd0, seenMask},
                        (f % 3 == 0) ? 32'h0000000f : 32'h0000000d);
        end
        checkOutput("t2FrameCount", {24'd0, frame_count}, 32'd7);

        // Test 3: entity 2 never answers; it times out and entity 3 still runs.
        div_cfg  = {4'd1, 4'd1, 4'd1, 4'd1};
        ent_done = 4'b1011;
        checkOutput("t3ErrBefore", {28'd0, timeout_err}, 32'd0);
        runFrame();
        checkOutput("t3Seen", {28'd0, seenMask}, 32'hf);
        checkOutput("t3Trig2At", trigAt[2], 32'd4);
        checkOutput("t3Trig3At", trigAt[3], 32'd68);
        checkOutput("t3Err", {28'd0, timeout_err}, 32'h4);
        ent_done = 4'b1111;
        runFrame();
        checkOutput("t3ErrSticky", {28'd0, timeout_err}, 32'h4);
        checkOutput("t3SeenAgain", {28'd0, seenMask}, 32'hf);

        // Test 4: a second frame_start while busy is dropped and flagged.
        clearTrack();
        applyStimulus(1'b1, 1'b0);
        expFrames++;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t4Overrun", {31'd0, overrun}, 32'd1);
        checkOutput("t4FrameCount", {24'd0, frame_count}, expFrames);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t4OverrunDrop", {31'd0, overrun}, 32'd0);
        drainFrame(1'b0);
        checkOutput("t4Pulses", pulseCount, 32'd4);
        checkOutput("t4Seen", {28'd0, seenMask}, 32'hf);
        checkOutput("t4FrameCountEnd", {24'd0, frame_count}, expFrames);

        // Test 5: paused frame_starts do nothing; divider phase is preserved.
        div_cfg = {4'd1, 4'd1, 4'd3, 4'd1};
        runFrame();
        checkOutput("t5FrameA", {28'd0, seenMask}, 32'hd);
        clearTrack();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("t5PauseBusy%0d", i), {31'd0, busy}, 32'd0);
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("t5PauseOverrun%0d", i), {31'd0, overrun}, 32'd0);
        end
        checkOutput("t5PausePulses", pulseCount, 32'd0);
        checkOutput("t5PauseFrameCount", {24'd0, frame_count}, expFrames);
        runFrame();
        checkOutput("t5FrameB", {28'd0, seenMask}, 32'hd);
        runFrame();
        checkOutput("t5FrameC", {28'd0, seenMask}, 32'hf);
        clearTrack();
        applyStimulus(1'b1, 1'b0);
        expFrames++;
        drainFrame(1'b1);
        checkOutput("t5MidPauseSeen", {28'd0, seenMask}, 32'hd);
        checkOutput("t5MidPausePulses", pulseCount, 32'd3);
        checkOutput("t5FrameCount", {24'd0, frame_count}, expFrames);
        pause = 1'b0;

        // Test 6: reset while waiting on entity 1 aborts the sequence.
        div_cfg  = {4'd1, 4'd1, 4'd1, 4'd1};
        ent_done = 4'b0001;
        clearTrack();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t6Trig1", {28'd0, trigger}, 32'h2);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t6BusyWait", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6RstTrigger", {28'd0, trigger}, 32'd0);
        checkOutput("t6RstBusy", {31'd0, busy}, 32'd0);
        checkOutput("t6RstFrameCount", {24'd0, frame_count}, 32'd0);
        checkOutput("t6RstErr", {28'd0, timeout_err}, 32'd0);
        @(posedge clk);
        #3;
        rst_n    = 1'b1;
        ent_done = 4'b1111;
        expFrames = 0;
        clearTrack();
        repeat (6) applyStimulus(1'b0, 1'b0);
        checkOutput("t6NoPulses", pulseCount, 32'd0);
        checkOutput("t6IdleBusy", {31'd0, busy}, 32'd0);

        // Frame counter wrap after 256 accepted frames.
        for (int f = 1; f <= 256; f++) begin
            runFrame();
            if (f == 255) checkOutput("wrap255", {24'd0, frame_count}, 32'd255);
        end
        checkOutput("wrap0", {24'd0, frame_count}, 32'd0);
        checkOutput("oneHot", multiHot, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
